// File: rtl/io_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package io_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push when full and pop when empty are ignored.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q;
    logic [AW:0]      rp_q;

    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty_o = (wp_q == rp_q);
    assign dout_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wp_q[AW-1:0]] <= din_i;
                wp_q                <= wp_q + 1'b1;
            end
            if (pop_i && !empty_o)
                rp_q <= rp_q + 1'b1;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// IO-bus UART transmitter: byte FIFO, status/overflow register and 8N1 baud FSM.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sel_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic        addr_i,
    input  logic [31:0] DATA_i,
    output logic [31:0] DATA_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DIV);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DIV - 1);

    logic        wr_en, rd_en, push, pop, full, empty;
    logic [7:0]  fifo_dout;
    logic [31:0] stat;

    tx_state_e      state_q;
    logic [BCW-1:0] bc_q;
    logic [7:0]     shift_q;
    logic [2:0]     idx_q;
    logic           tx_q, busy_q, ovf_q;
    logic [7:0]     last_q;
    logic [31:0]    data_q;

    logic unused_data;
    assign unused_data = ^{DATA_i[31:8], DATA_i[7:4], DATA_i[2:0]};

    assign wr_en = sel_i & wr_i;
    assign rd_en = sel_i & rd_i & ~wr_i;
    assign push  = wr_en && (addr_i == ADDR_DATA);

    // Head is taken either from IDLE or at the end of a stop bit for back-to-back frames.
    always_comb begin
        pop = 1'b0;
        if (!empty)
            pop = (state_q == IDLE) || ((state_q == STOP) && (bc_q == BC_LAST));
    end

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (DATA_i[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        stat          = 32'b0;
        stat[ST_BUSY]  = busy_q;
        stat[ST_EMPTY] = empty;
        stat[ST_FULL]  = full;
        stat[ST_OVF]   = ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q  <= 1'b0;
            last_q <= 8'h00;
            data_q <= 32'h0;
        end else begin
            if (push && !full)
                last_q <= DATA_i[7:0];
            if (push && full)
                ovf_q <= 1'b1;
            else if (wr_en && (addr_i == ADDR_STAT) && DATA_i[3])
                ovf_q <= 1'b0;
            if (rd_en)
                data_q <= (addr_i == ADDR_DATA) ? {24'b0, last_q} : stat;
        end
    end

    // tx/busy are registered from the current state, so the line lags the state by one clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bc_q    <= '0;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE);
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        shift_q <= fifo_dout;
                        bc_q    <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bc_q == BC_LAST) begin
                        bc_q    <= '0;
                        idx_q   <= 3'd0;
                        state_q <= DATA;
                    end else begin
                        bc_q <= bc_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bc_q == BC_LAST) begin
                        bc_q    <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7)
                            state_q <= STOP;
                    end else begin
                        bc_q <= bc_q + 1'b1;
                    end
                end
                default: begin
                    if (bc_q == BC_LAST) begin
                        bc_q <= '0;
                        if (!empty) begin
                            shift_q <= fifo_dout;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        bc_q <= bc_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign DATA_o = data_q;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at DIV=10 with a background 8N1 line decoder.
module tb_io_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0, wr = 1'b0, rd = 1'b0, addr = 1'b0;
    logic [31:0] din = 32'h0;
    logic [31:0] dout;
    logic        tx, busy;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int nfall = 0;
    logic tx_prev = 1'b1;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];

    io_uart_tx #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .sel_i(sel), .wr_i(wr), .rd_i(rd),
        .addr_i(addr), .DATA_i(din), .DATA_o(dout), .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        tx_prev <= tx;
        if (tx_prev === 1'b1 && tx === 1'b0) nfall <= nfall + 1;
    end

    // Line decoder: samples each bit mid-way after the start edge.
    initial begin
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t = cyc;
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = tx;
                end
                repeat (10) @(negedge clk);
                rx_q.push_back(b);
                rx_t.push_back(t);
                rx_stop.push_back(tx);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; din = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic a);
        sel = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin @(negedge clk); k++; end
        chk("rx_wait", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin @(negedge clk); k++; end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, base, nf;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", dout, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        bus_rd(1'b1);
        chk("stat_idle", dout, 32'h2);

        // Single byte, cycle-exact line check
        base = rx_q.size();
        bus_wr(1'b0, 32'h0000_00A5);
        n = cyc;
        @(negedge clk);
        chk("lat_n1_tx", 32'(tx), 32'd1);
        @(negedge clk);
        chk("lat_n2_tx", 32'(tx), 32'd0);
        chk("lat_n2_busy", 32'(busy), 32'd1);
        chk("lat_n2_cyc", 32'(cyc - n), 32'd2);
        repeat (4) @(negedge clk);
        chk("a5_start", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx;
        end
        chk("a5_bits", 32'(b), 32'hA5);
        repeat (10) @(negedge clk);
        chk("a5_stop", 32'(tx), 32'd1);
        repeat (5) @(negedge clk);
        chk("a5_busy_99", 32'(busy), 32'd1);
        @(negedge clk);
        chk("a5_busy_100", 32'(busy), 32'd0);
        wait_rx(base + 1);
        chk("a5_mon", 32'(rx_q[base]), 32'hA5);

        // Read-back of the last accepted byte
        base = rx_q.size();
        bus_wr(1'b0, 32'h1234_56C3);
        bus_rd(1'b0);
        chk("rd_last", dout, 32'h0000_00C3);
        wait_rx(base + 1);
        chk("c3_mon", 32'(rx_q[base]), 32'hC3);
        wait_idle();

        // Back-to-back frames
        base = rx_q.size();
        bus_wr(1'b0, 32'h01);
        bus_wr(1'b0, 32'h80);
        wait_rx(base + 2);
        chk("b2b_0", 32'(rx_q[base]), 32'h01);
        chk("b2b_1", 32'(rx_q[base+1]), 32'h80);
        chk("b2b_gap", 32'(rx_t[base+1] - rx_t[base]), 32'd100);
        chk("b2b_stop", 32'(rx_stop[base]), 32'd1);
        wait_idle();

        // Overflow: 6 writes, one in flight plus 4 queued
        base = rx_q.size();
        for (int i = 0; i < 6; i++) bus_wr(1'b0, 32'(8'h30 + i));
        bus_rd(1'b1);
        chk("ovf_stat", dout, 32'h0000_000D);
        bus_wr(1'b1, 32'h8);
        bus_rd(1'b1);
        chk("ovf_clr", dout, 32'h0000_0005);
        wait_rx(base + 5);
        for (int i = 0; i < 5; i++) chk("ovf_byte", 32'(rx_q[base+i]), 32'(8'h30 + i));
        wait_idle();
        repeat (150) @(negedge clk);
        chk("ovf_count", 32'(rx_q.size() - base), 32'd5);
        bus_rd(1'b1);
        chk("ovf_after", dout, 32'h2);

        // Read/write collision: push wins, DATA_o holds
        base = rx_q.size();
        sel = 1'b1; wr = 1'b1; rd = 1'b1; addr = 1'b0; din = 32'h5A;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; rd = 1'b0;
        chk("coll_dout", dout, 32'h2);
        wait_rx(base + 1);
        chk("coll_byte", 32'(rx_q[base]), 32'h5A);
        wait_idle();

        // Reset mid-frame
        bus_wr(1'b0, 32'h11);
        bus_wr(1'b0, 32'h22);
        bus_wr(1'b0, 32'h33);
        repeat (30) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dout", dout, 32'h0);
        rst = 1'b0;
        bus_rd(1'b1);
        chk("mid_stat", dout, 32'h2);
        nf = nfall;
        repeat (400) @(negedge clk);
        chk("mid_nofall", 32'(nfall - nf), 32'd0);
        chk("mid_tx_idle", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor IO bus, one decoded slot beside the plain IO data registers.
- The CPU writes bytes into a small FIFO using the same sel/wr/rd strobe protocol as the IO registers. A baud-rate FSM then serialises each byte as an 8N1 frame on tx_o.
- A status word is readable so firmware can poll for free space and completion.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. Local DIV = CLK_HZ/BAUD (integer division) is the clocks per bit, and must be >= 2.
- FIFO_DEPTH, 4, number of byte entries. Must be a power of 2 and >= 2.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- sel_i  in  1  slot select from the IO address decoder.
- wr_i  in  1  write strobe, qualified by sel_i.
- rd_i  in  1  read strobe, qualified by sel_i.
- addr_i  in  1  0 = data register, 1 = status/control register.
- DATA_i  in  32  write data.
- DATA_o  out  32  registered read data.
- tx_o  out  1  serial output, idle high.
- busy_o  out  1  1 while the FSM is not IDLE.

Behaviour:
- Reset (rst_i=1 at a rising edge) takes effect that edge and overrides everything, including a frame in progress. Resulting values:
  - tx_o=1, busy_o=0, DATA_o=0.
  - FIFO empty, overflow flag=0, FSM=IDLE, baud counter=0.
- Write, addr 0 (sel_i&wr_i&addr_i==0):
  - If the FIFO is not full, DATA_i[7:0] is pushed; DATA_i[31:8] are ignored.
  - If the FIFO is full, the byte is dropped and the sticky overflow flag is set.
  - Fullness is sampled before any same-cycle pop, so a pop in the same cycle does not make room.
- Write, addr 1: DATA_i[3]=1 clears overflow. All other bits are ignored.
- wr_i has priority over rd_i when both are high.
- Read (sel_i&rd_i&~wr_i): DATA_o loads at the edge and holds until the next read or reset.
  - addr 0: DATA_o = {24'b0, last byte accepted into the FIFO}.
  - addr 1: DATA_o = {28'b0, overflow, full, empty, busy}, i.e. bit3 = overflow … bit0 = busy.
  - Reads have no side effects.
- FSM states are IDLE, START, DATA, STOP. The baud counter bc counts 0..DIV-1; each bit occupies exactly DIV clocks.
  - IDLE: tx_o=1. If the FIFO is not empty, pop the head into the shift register, set bc=0 and go to START.
  - START: tx_o=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0], LSB first. At bc==DIV-1, shift right and increment the index; after index 7 go to STOP.
  - STOP: tx_o=1 for DIV clocks. At bc==DIV-1:
    - if the FIFO is not empty, pop and go directly to START (back-to-back frames, no extra idle bit);
    - otherwise go to IDLE.
- tx_o is registered.
- Latency: a write at edge N into an empty FIFO with the FSM in IDLE:
  - the FIFO shows not-empty after N;
  - the pop happens at N+1;
  - tx_o falls at N+2.
- Frame length is 10*DIV clocks. busy_o=1 from the edge where tx_o falls until the return to IDLE.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and the low bits are equal.
  - empty = the pointers are equal.
- A simultaneous push and pop on a non-full, non-empty FIFO keeps the count constant.
- Reads with sel_i=0 are ignored. DATA_o never changes without a read or a reset.

Decomposition:
- Package io_uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP);
  - status bit index constants (ST_BUSY=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3);
  - ADDR_DATA/ADDR_STAT constants.
- One sub-module io_sync_fifo, parameterised by width (8) and depth, with push/pop/full/empty.
- The top level holds the bus decode, the status register, the baud counter and the FSM.

Test Plan:
- Single byte. CLK_HZ=1000, BAUD=100 (DIV=10). Write 0xA5 to addr 0 at edge N →
  - tx_o falls at N+2;
  - bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then stop=1;
  - busy_o deasserts 100 clocks after the fall.
- Back-to-back. Write 0x01 then 0x80 on consecutive cycles → two frames with no idle gap between stop and start; decoded bytes are 0x01, 0x80.
- Overflow. Hold the FSM busy and write 6 bytes (FIFO_DEPTH=4):
  - status read shows full=1, ovf=1 (DATA_o=0x0D while busy);
  - writing addr 1 with 0x8 clears ovf;
  - exactly 5 bytes are transmitted (one in flight plus 4 queued).
- Status polling. Read status when idle and empty → DATA_o=0x00000002. Read addr 0 after writing 0x1234_56C3 → DATA_o=0x000000C3.
- Reset mid-frame. Assert rst_i during DATA of the first of 3 queued bytes →
  - tx_o=1 and busy_o=0 at the next edge;
  - status reads 0x2;
  - no further frames are sent.
- Read/write collision. sel_i=wr_i=rd_i=1 on addr 0 → the byte is pushed and DATA_o is unchanged.
